mac_seq_ctrl: RTL and testbench

Sequencer for the mac3_acc digit-classifier datapath. On a start pulse it fetches NUM_NEURONS×WORDS_PER_NEURON pixel/weight word pairs from the operand memories and presents them to the MAC, one pair per cycle. It pulses the accumulator clear on the first word of each neuron and captures each neuron's accumulated result after the MAC latency. It signals done when all results have been emitted, replacing the hand-timed counting and reset sequencing currently done in the bench.

---
 rtl/mac_ctrl_pkg.sv | 16 +
 rtl/mac_seq_ctrl_if.sv | 39 +++
 rtl/mac_seq_ctrl_res_tag_pipe.sv | 27 ++
 rtl/mac_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared types and default widths for the mac3_acc sequencer (mac_seq_ctrl).
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 128;
  localparam int ACC_W_DEF  = 22;
  localparam int BIAS_W_DEF = 8;
  localparam int IDX_W      = 4;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand-memory, MAC and result bus between mac_seq_ctrl (master) and the datapath (slave).
interface mac_seq_ctrl_if #(
  parameter int DATA_W = mac_ctrl_pkg::DATA_W_DEF,
  parameter int ACC_W  = mac_ctrl_pkg::ACC_W_DEF,
  parameter int BIAS_W = mac_ctrl_pkg::BIAS_W_DEF,
  parameter int ADDR_W = 6,
  parameter int IDX_W  = mac_ctrl_pkg::IDX_W
) ();

  // No ready signals anywhere: the operand memories answer exactly one cycle
  // after mem_rd_en, and res_valid is a one-cycle strobe the consumer must
  // take while it is high (res_idx/res_data hold until the next strobe).
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    p_in;
  logic [DATA_W-1:0]    w_in;
  logic [DATA_W-1:0]    p_out;
  logic [DATA_W-1:0]    w_out;
  logic [BIAS_W-1:0]    b_out;
  logic                 acc_clr;
  logic [ACC_W-1:0]     acc_dout;
  logic                 res_valid;
  logic [IDX_W-1:0]     res_idx;
  logic [ACC_W-1:0]     res_data;
  mac_ctrl_pkg::state_t dbg_state;

  modport master (
    output mem_rd_en, mem_addr, p_out, w_out, b_out, acc_clr,
    output res_valid, res_idx, res_data, dbg_state,
    input  p_in, w_in, acc_dout
  );

  modport slave (
    input  mem_rd_en, mem_addr, p_out, w_out, b_out, acc_clr,
    input  res_valid, res_idx, res_data, dbg_state,
    output p_in, w_in, acc_dout
  );

endinterface

// File: rtl/mac_seq_ctrl_res_tag_pipe.sv
// res_tag_pipe: DEPTH-deep 1-bit shift register carrying the "last word of a neuron" tag.
module res_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= din;
    end
  end else begin : g_multi
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: fetches operand pairs, drives the MAC and captures one result per neuron.
// Define MAC_SEQ_ARGMAX_EN to add max_idx/max_val (running signed argmax of the results).
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_W           = DATA_W_DEF,
  parameter int ACC_W            = ACC_W_DEF,
  parameter int BIAS_W           = BIAS_W_DEF,
  parameter int WORDS_PER_NEURON = 4,
  parameter int NUM_NEURONS      = 10,
  parameter int ADDR_W           = 6,
  parameter int MAC_LAT          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIAS_W-1:0] b_cfg,
  output logic              busy,
  output logic              done,
`ifdef MAC_SEQ_ARGMAX_EN
  output logic [IDX_W-1:0]  max_idx,
  output logic [ACC_W-1:0]  max_val,
`endif
  mac_seq_ctrl_if.master    bus
);

  localparam int TOTAL = NUM_NEURONS * WORDS_PER_NEURON;
  localparam int WW    = (WORDS_PER_NEURON > 1) ? $clog2(WORDS_PER_NEURON) : 1;
  localparam int NC_W  = IDX_W + 1;

  state_t            state, state_nxt;
  logic              fetch_en;
  logic              start_acc;
  logic              addr_last;
  logic              all_done;

  logic [ADDR_W-1:0] addr;
  logic [BIAS_W-1:0] b_reg;
  logic              rd_vld;
  logic              p_vld;
  logic [WW-1:0]     in_word;
  logic [WW-1:0]     p_word;
  logic [DATA_W-1:0] p_reg, w_reg;
  logic [NC_W-1:0]   ncnt;
  logic              tag_in, tag_out;
  logic              res_vld;
  logic [IDX_W-1:0]  res_idx_r;
  logic [ACC_W-1:0]  res_data_r;

  assign start_acc = (state == IDLE) && start;
  assign addr_last = (addr == ADDR_W'(TOTAL - 1));
  assign all_done  = (ncnt == NC_W'(NUM_NEURONS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        fetch_en = 1'b1;
        busy     = 1'b1;
        if (addr_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (all_done) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The tag marks the word that completes a neuron as it is loaded onto p_out;
  // it emerges MAC_LAT edges later, when acc_dout holds that neuron's total.
  assign tag_in = rd_vld && (in_word == WW'(WORDS_PER_NEURON - 1));

  res_tag_pipe #(.DEPTH(MAC_LAT)) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      b_reg      <= '0;
      rd_vld     <= 1'b0;
      p_vld      <= 1'b0;
      in_word    <= '0;
      p_word     <= '0;
      p_reg      <= '0;
      w_reg      <= '0;
      ncnt       <= '0;
      res_vld    <= 1'b0;
      res_idx_r  <= '0;
      res_data_r <= '0;
    end else begin
      rd_vld  <= fetch_en;
      p_vld   <= rd_vld;
      res_vld <= tag_out;

      if (start_acc) begin
        addr  <= '0;
        b_reg <= b_cfg;
      end else if (fetch_en && !addr_last) begin
        addr <= addr + 1'b1;
      end

      if (start_acc) begin
        in_word <= '0;
      end else if (rd_vld) begin
        p_reg   <= bus.p_in;
        w_reg   <= bus.w_in;
        p_word  <= in_word;
        in_word <= (in_word == WW'(WORDS_PER_NEURON - 1)) ? '0 : in_word + 1'b1;
      end

      if (start_acc) begin
        ncnt <= '0;
      end else if (tag_out) begin
        res_data_r <= bus.acc_dout;
        res_idx_r  <= ncnt[IDX_W-1:0];
        ncnt       <= ncnt + 1'b1;
      end
    end
  end

`ifdef MAC_SEQ_ARGMAX_EN
  // Strict greater-than keeps the lower index on ties; updates one edge after each capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_idx <= '0;
      max_val <= {1'b1, {(ACC_W-1){1'b0}}};
    end else if (start_acc) begin
      max_idx <= '0;
      max_val <= {1'b1, {(ACC_W-1){1'b0}}};
    end else if (res_vld && ($signed(res_data_r) > $signed(max_val))) begin
      max_idx <= res_idx_r;
      max_val <= res_data_r;
    end
  end
`endif

  assign bus.mem_rd_en = fetch_en;
  assign bus.mem_addr  = addr;
  assign bus.p_out     = p_reg;
  assign bus.w_out     = w_reg;
  assign bus.b_out     = b_reg;
  assign bus.acc_clr   = p_vld && (p_word == '0);
  assign bus.res_valid = res_vld;
  assign bus.res_idx   = res_idx_r;
  assign bus.res_data  = res_data_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a registered operand memory and a one-edge accumulator model.
module tb_mac_seq_ctrl;
  import mac_ctrl_pkg::*;

  localparam int DW       = 128;
  localparam int AW       = 22;
  localparam int BW       = 8;
  localparam int ADW      = 6;
  localparam int WPN      = 4;
  localparam int NN       = 10;
  localparam int LAT      = 2;
  localparam int TOTAL    = NN * WPN;
  localparam int FIRST_RV = 5 + LAT;
  localparam int LAST_RV  = FIRST_RV + WPN * (NN - 1);
  localparam int DONE_E   = LAST_RV + 1;
  localparam int NCP      = 14;

  typedef struct {
    int          edge_n;
    logic [16:0] vec;
  } cp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] b_cfg;
  logic          busy;
  logic          done;
`ifdef MAC_SEQ_ARGMAX_EN
  logic [3:0]    max_idx;
  logic [AW-1:0] max_val;
`endif

  mac_seq_ctrl_if #(.DATA_W(DW), .ACC_W(AW), .BIAS_W(BW), .ADDR_W(ADW)) bus ();

  mac_seq_ctrl #(
    .DATA_W(DW), .ACC_W(AW), .BIAS_W(BW), .WORDS_PER_NEURON(WPN),
    .NUM_NEURONS(NN), .ADDR_W(ADW), .MAC_LAT(LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .b_cfg   (b_cfg),
    .busy    (busy),
    .done    (done),
`ifdef MAC_SEQ_ARGMAX_EN
    .max_idx (max_idx),
    .max_val (max_val),
`endif
    .bus     (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // operand memories (one-cycle registered read) and accumulator model
  logic [DW-1:0]        mem_p [TOTAL];
  logic [DW-1:0]        mem_w [TOTAL];
  logic signed [AW-1:0] acc_q = '0;
  logic signed [AW-1:0] mac_x;

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.p_in <= mem_p[bus.mem_addr];
      bus.w_in <= mem_w[bus.mem_addr];
    end
  end

  assign mac_x = bus.p_out[AW-1:0];
  always @(posedge clk) acc_q <= bus.acc_clr ? mac_x : acc_q + mac_x;
  assign bus.acc_dout = acc_q;

  // scoreboard
  int            errors = 0;
  int            checks = 0;
  int            sums [NN];
  logic [AW-1:0] exp_q [$];
  cp_t           tbl [NCP];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cp_t mk(int e, state_t s, logic rd, int a, logic clr, logic rv,
                             int idx, logic dn, logic bsy);
    cp_t r;
    r.edge_n = e;
    r.vec    = {s, rd, 6'(a), clr, rv, 4'(idx), dn, bsy};
    return r;
  endfunction

  function automatic logic [16:0] act_vec();
    return {bus.dbg_state, bus.mem_rd_en, bus.mem_addr, bus.acc_clr, bus.res_valid,
            bus.res_idx, done, busy};
  endfunction

  // word k of neuron n contributes 10*k for k>0 and the remainder for k=0
  task automatic load_mem();
    for (int a = 0; a < TOTAL; a++) begin
      int            v;
      logic [AW-1:0] v22;
      v   = (a % WPN == 0) ? sums[a / WPN] - 60 : (a % WPN) * 10;
      v22 = AW'(v);
      mem_p[a] = {64'(a), 42'd0, v22};
      mem_w[a] = ~mem_p[a];
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    b_cfg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctrl"}, {bus.mem_rd_en, bus.mem_addr, bus.b_out, bus.acc_clr, bus.res_valid,
                           bus.res_idx, busy, done}, '0);
    check({tag, "_p_out"}, bus.p_out, '0);
    check({tag, "_w_out"}, bus.w_out, '0);
    check({tag, "_res_data"}, bus.res_data, '0);
  endtask

  // drive driver: start pulse (or held start) and per-cycle comparison against the timing model
  task automatic run_check(input logic [BW-1:0] bias, input bit hold, input bit use_tbl);
    int ti     = 0;
    int n_done = 0;
    int rv_n   = 0;
    int best   = 0;
    exp_q.delete();
    for (int n = 0; n < NN; n++) begin
      exp_q.push_back(AW'(sums[n]));
      if (sums[n] > sums[best]) best = n;
    end
    load_mem();
    @(negedge clk);
    start = 1'b1;
    b_cfg = bias;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int e = 0; e <= DONE_E + 1; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (use_tbl && ti < NCP && tbl[ti].edge_n == e) begin
        check($sformatf("checkpoint_e%0d", e), act_vec(), tbl[ti].vec);
        ti++;
      end
      check("mem_rd_en", bus.mem_rd_en, e <= TOTAL - 1);
      check("mem_addr", bus.mem_addr, (e <= TOTAL - 1) ? e : TOTAL - 1);
      if (e >= 2 && e <= TOTAL + 1) begin
        check("p_out", bus.p_out, mem_p[e-2]);
        check("w_out", bus.w_out, mem_w[e-2]);
      end
      check("acc_clr", bus.acc_clr, (e >= 2) && (e <= TOTAL + 1) && ((e - 2) % WPN == 0));
      check("res_valid", bus.res_valid,
            (e >= FIRST_RV) && (e <= LAST_RV) && ((e - FIRST_RV) % WPN == 0));
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_result", 1'b1, 1'b0);
        end else begin
          check("res_data", bus.res_data, exp_q.pop_front());
          check("res_idx", bus.res_idx, rv_n);
          rv_n++;
        end
      end
      if (done) n_done++;
      check("done", done, e == DONE_E);
      check("busy", busy, e <= DONE_E);
      if (busy) check("b_out", bus.b_out, bias);
`ifdef MAC_SEQ_ARGMAX_EN
      if (e == DONE_E) begin
        check("max_idx", max_idx, best);
        check("max_val", max_val, AW'(sums[best]));
      end
`endif
    end
    start = 1'b0;
    check("done_count", n_done, 1);
    check("results_left", exp_q.size(), 0);
  endtask

  initial begin
    int n_done;

    tbl[0]  = mk(0,      FETCH, 1, 0,  0, 0, 0, 0, 1);
    tbl[1]  = mk(1,      FETCH, 1, 1,  0, 0, 0, 0, 1);
    tbl[2]  = mk(2,      FETCH, 1, 2,  1, 0, 0, 0, 1);
    tbl[3]  = mk(3,      FETCH, 1, 3,  0, 0, 0, 0, 1);
    tbl[4]  = mk(6,      FETCH, 1, 6,  1, 0, 0, 0, 1);
    tbl[5]  = mk(7,      FETCH, 1, 7,  0, 1, 0, 0, 1);
    tbl[6]  = mk(8,      FETCH, 1, 8,  0, 0, 0, 0, 1);
    tbl[7]  = mk(11,     FETCH, 1, 11, 0, 1, 1, 0, 1);
    tbl[8]  = mk(38,     FETCH, 1, 38, 1, 0, 7, 0, 1);
    tbl[9]  = mk(39,     FETCH, 1, 39, 0, 1, 8, 0, 1);
    tbl[10] = mk(40,     DRAIN, 0, 39, 0, 0, 8, 0, 1);
    tbl[11] = mk(43,     DRAIN, 0, 39, 0, 1, 9, 0, 1);
    tbl[12] = mk(DONE_E, DONE,  0, 39, 0, 0, 9, 1, 1);
    tbl[13] = mk(45,     IDLE,  0, 39, 0, 0, 9, 0, 0);

    for (int n = 0; n < NN; n++) sums[n] = 100 * n - 300;

    do_reset();
    check_zero_outputs("reset");
    check("reset_state", bus.dbg_state, IDLE);
`ifdef MAC_SEQ_ARGMAX_EN
    check("reset_max_idx", max_idx, 0);
    check("reset_max_val", max_val, {1'b1, {(AW-1){1'b0}}});
`endif

    run_check(8'd11, 1'b0, 1'b1);
    run_check(8'd11, 1'b1, 1'b0);
    run_check(8'd37, 1'b0, 1'b0);

    // asynchronous reset in the middle of a run
    load_mem();
    @(negedge clk);
    start = 1'b1;
    b_cfg = 8'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrun_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done || bus.res_valid || busy) n_done++;
    end
    check("no_activity_after_reset", n_done, 0);
    run_check(8'd11, 1'b0, 1'b1);

`ifdef MAC_SEQ_ARGMAX_EN
    sums = '{5, -2, 90, 90, 1, 2, 3, 4, 5, 6};
    run_check(8'd11, 1'b0, 1'b0);
    check("argmax_idx_ties", max_idx, 2);
    check("argmax_val_ties", max_val, AW'(90));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
